// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the repeated-subtraction divider front end:
//   - state_e     : feeder FSM states, IDLE=0 through DONE=5
//   - DIV_W       : default operand/result width
//   - DIV_TIMEOUT : default WAIT watchdog limit in cycles (>= 2^DIV_W + 8)
//   - DIV_SAT     : all-ones saturation value reported as the quotient on
//                   divide-by-zero and on timeout
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_W       = 8;
  localparam int DIV_TIMEOUT = 512;

  localparam logic [DIV_W-1:0] DIV_SAT = {DIV_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_LOAD_N = 3'd2,
    ST_LOAD_P = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/div_timeout_ctr.sv
// -----------------------------------------------------------------------------
// div_timeout_ctr
// Watchdog counter for the feeder WAIT state. Counts up from 0 while enabled
// and raises tc_o when the count reaches TIMEOUT-1; it then holds there until
// cleared. Clear has priority over enable.
//
// Ports:
//   Clk    in  clock, rising edge
//   Rst_n  in  asynchronous active-low reset
//   clr_i  in  synchronous clear to 0
//   en_i   in  count enable
//   tc_o   out terminal count (count == TIMEOUT-1)
// -----------------------------------------------------------------------------
module div_timeout_ctr #(
  parameter int TIMEOUT = 512
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tc_o = (count_q == CW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/div_operand_feeder.sv
// -----------------------------------------------------------------------------
// div_operand_feeder
// Front-end sequencer for the repeated-subtraction divider. Accepts an
// (n, p) pair on a valid/ready handshake, replays it to the divider as
// Start pulse -> dividend -> divisor on Data_in, waits for Stop, and captures
// quotient/remainder into a held, handshaked result register. A watchdog
// aborts WAIT after TIMEOUT cycles (Out_q = all ones, Out_r = n, Out_to = 1).
//
// Build option:
//   DIV_ZERO_BYPASS_EN - when defined, p == 0 at accept skips the divider and
//                        reports Out_q = all ones, Out_r = n, Out_dz = 1 in the
//                        cycle after accept. When undefined, Out_dz is tied 0
//                        and p == 0 is forwarded (ends by timeout).
//
// Ports:
//   Clk, Rst_n           clock (rising edge), async active-low reset
//   In_valid/In_ready    operand handshake; In_ready is combinational (IDLE)
//   In_n, In_p           dividend, divisor
//   Start, Data_in       to divider: start pulse, serial operand bus
//   Stop, Qw, Nw         from divider: done level, quotient, remainder
//   Out_valid/Out_ready  result handshake
//   Out_q, Out_r         quotient, remainder
//   Out_dz, Out_to       divide-by-zero flag, timeout flag
// All outputs except In_ready are registered.
// -----------------------------------------------------------------------------
module div_operand_feeder
  import div_pkg::*;
#(
  parameter int W       = DIV_W,
  parameter int TIMEOUT = DIV_TIMEOUT
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         In_valid,
  output logic         In_ready,
  input  logic [W-1:0] In_n,
  input  logic [W-1:0] In_p,
  output logic         Start,
  output logic [W-1:0] Data_in,
  input  logic         Stop,
  input  logic [W-1:0] Qw,
  input  logic [W-1:0] Nw,
  output logic         Out_valid,
  input  logic         Out_ready,
  output logic [W-1:0] Out_q,
  output logic [W-1:0] Out_r,
  output logic         Out_dz,
  output logic         Out_to
);

  localparam logic [W-1:0] SAT = {W{1'b1}};

  state_e       state_q, state_d;
  logic [W-1:0] n_q, n_d;
  logic [W-1:0] p_q, p_d;
  logic         start_q, start_d;
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic [W-1:0] q_q, q_d;
  logic [W-1:0] r_q, r_d;
  logic         to_q, to_d;
`ifdef DIV_ZERO_BYPASS_EN
  logic         dz_q, dz_d;
`endif
  logic         wait_tc;

  // Counter runs only in WAIT and restarts from 0 on every entry.
  div_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr_i (state_q != ST_WAIT),
    .en_i  (state_q == ST_WAIT),
    .tc_o  (wait_tc)
  );

  // The divider-facing outputs are registered, so they are computed from the
  // transition being taken: Start rises together with entry into START.
  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    p_d     = p_q;
    start_d = 1'b0;
    data_d  = data_q;
    valid_d = valid_q;
    q_d     = q_q;
    r_d     = r_q;
    to_d    = to_q;
`ifdef DIV_ZERO_BYPASS_EN
    dz_d    = dz_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (In_valid) begin
          n_d = In_n;
          p_d = In_p;
`ifdef DIV_ZERO_BYPASS_EN
          if (In_p == '0) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
            q_d     = SAT;
            r_d     = In_n;
            dz_d    = 1'b1;
            to_d    = 1'b0;
          end else
`endif
          begin
            state_d = ST_START;
            start_d = 1'b1;
            data_d  = '0;
          end
        end
      end
      ST_START: begin
        state_d = ST_LOAD_N;
        data_d  = n_q;
      end
      ST_LOAD_N: begin
        state_d = ST_LOAD_P;
        data_d  = p_q;
      end
      ST_LOAD_P: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Stop outranks the watchdog when both land in the same cycle.
        if (Stop) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          q_d     = Qw;
          r_d     = Nw;
          to_d    = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
          dz_d    = 1'b0;
`endif
        end else if (wait_tc) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          q_d     = SAT;
          r_d     = n_q;
          to_d    = 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
          dz_d    = 1'b0;
`endif
        end
      end
      ST_DONE: begin
        if (Out_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      p_q     <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      to_q    <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      p_q     <= p_d;
      start_q <= start_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      q_q     <= q_d;
      r_q     <= r_d;
      to_q    <= to_d;
`ifdef DIV_ZERO_BYPASS_EN
      dz_q    <= dz_d;
`endif
    end
  end

  // State resets to IDLE asynchronously, so In_ready is high during reset.
  assign In_ready  = (state_q == ST_IDLE);
  assign Start     = start_q;
  assign Data_in   = data_q;
  assign Out_valid = valid_q;
  assign Out_q     = q_q;
  assign Out_r     = r_q;
  assign Out_to    = to_q;
`ifdef DIV_ZERO_BYPASS_EN
  assign Out_dz    = dz_q;
`else
  assign Out_dz    = 1'b0;
`endif

endmodule

// File: tb/tb_div_operand_feeder.sv
// -----------------------------------------------------------------------------
// tb_div_operand_feeder
// Self-checking bench for div_operand_feeder. A behavioural divider answers
// the Start / dividend / divisor sequence by repeated subtraction and holds
// Stop high until the next Start. Expected results come from plain n/p, n%p
// arithmetic and the documented timing rules.
// -----------------------------------------------------------------------------
module tb_div_operand_feeder;
  import div_pkg::*;

  localparam int W       = DIV_W;
  localparam int TIMEOUT = DIV_TIMEOUT;
  localparam logic [W-1:0] STUB_Q = 8'hA5;
  localparam logic [W-1:0] STUB_R = 8'h3C;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         In_valid = 1'b0;
  logic         In_ready;
  logic [W-1:0] In_n = '0;
  logic [W-1:0] In_p = '0;
  logic         Start;
  logic [W-1:0] Data_in;
  logic         Stop;
  logic [W-1:0] Qw;
  logic [W-1:0] Nw;
  logic         Out_valid;
  logic         Out_ready = 1'b0;
  logic [W-1:0] Out_q;
  logic [W-1:0] Out_r;
  logic         Out_dz;
  logic         Out_to;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  div_operand_feeder #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .In_n      (In_n),
    .In_p      (In_p),
    .Start     (Start),
    .Data_in   (Data_in),
    .Stop      (Stop),
    .Qw        (Qw),
    .Nw        (Nw),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Out_q     (Out_q),
    .Out_r     (Out_r),
    .Out_dz    (Out_dz),
    .Out_to    (Out_to)
  );

  // Behavioural divider: Start clears Stop, next cycle takes n, the one after
  // takes p, then one subtraction per cycle until remainder < p.
  // stub_mode freezes it (Stop never rises on its own, fixed Qw/Nw).
  int           phase = 0;
  logic [W-1:0] dn = '0, dp = '0, quo = '0, rem = '0;
  logic         div_stop = 1'b0;
  logic         stub_mode = 1'b0;
  logic         force_stop = 1'b0;

  always @(posedge Clk) begin
    if (Start) begin
      phase    <= 1;
      div_stop <= 1'b0;
    end else begin
      case (phase)
        1: begin dn <= Data_in; phase <= 2; end
        2: begin dp <= Data_in; rem <= dn; quo <= '0; phase <= 3; end
        3: if (!stub_mode) begin
             if (rem >= dp) begin
               rem <= rem - dp;
               quo <= quo + 1'b1;
             end else begin
               div_stop <= 1'b1;
               phase    <= 0;
             end
           end
        default: ;
      endcase
    end
  end

  assign Stop = div_stop | force_stop;
  assign Qw   = stub_mode ? STUB_Q : quo;
  assign Nw   = stub_mode ? STUB_R : rem;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // mode 0: real divider; mode 1: divider never stops; mode 2: divider
  // stubbed, Stop forced high on the watchdog terminal cycle only.
  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] p,
                        input int hold, input int mode);
    logic [W-1:0] eq, er;
    logic         edz, eto;
    int           evc;   // expected Out_valid cycle; -1 = Stop cycle + 1
    int           c, w, starts, first_start, stop_c, valid_c;

    // Reference result from the operation rules.
    edz = 1'b0;
    if (mode == 2) begin
      eq = STUB_Q; er = STUB_R; eto = 1'b0; evc = 4 + TIMEOUT;
    end else if (mode == 1) begin
      eq = {W{1'b1}}; er = n; eto = 1'b1; evc = 4 + TIMEOUT;
    end else if (p != 0) begin
      eq = n / p; er = n % p; eto = 1'b0; evc = -1;
    end else begin
`ifdef DIV_ZERO_BYPASS_EN
      eq = {W{1'b1}}; er = n; edz = 1'b1; eto = 1'b0; evc = 1;
`else
      eq = {W{1'b1}}; er = n; eto = 1'b1; evc = 4 + TIMEOUT;
`endif
    end
    stub_mode = (mode != 0);

    w = 0;
    while (!In_ready && w < 50) begin
      @(negedge Clk);
      w++;
    end
    check("in_ready_before_accept", 32'(In_ready), 32'd1);

    In_valid = 1'b1;
    In_n = n;
    In_p = p;
    @(posedge Clk);
    @(negedge Clk);
    In_valid = 1'b0;
    In_n = W'($urandom);
    In_p = W'($urandom);

    c = 1; starts = 0; first_start = -1; stop_c = -1; valid_c = -1;
    while (c < 4 + TIMEOUT + 20) begin
      if (mode == 2) force_stop = (c == 3 + TIMEOUT);
      #1;
      if (Start) begin
        starts++;
        if (first_start < 0) first_start = c;
      end
      if (c >= 4 && Stop && stop_c < 0) stop_c = c;
      if (evc != 1 && c == 2) check("data_in_n", 32'(Data_in), 32'(n));
      if (evc != 1 && c == 3) check("data_in_p", 32'(Data_in), 32'(p));
      if (Out_valid) begin
        valid_c = c;
        break;
      end
      @(negedge Clk);
      c++;
    end
    force_stop = 1'b0;

    check("valid_cycle", 32'(valid_c), (evc < 0) ? 32'(stop_c + 1) : 32'(evc));
    if (evc == 1) begin
      check("start_count", 32'(starts), 32'd0);
    end else begin
      check("start_count", 32'(starts), 32'd1);
      check("start_cycle", 32'(first_start), 32'd1);
    end
    check("out_q", 32'(Out_q), 32'(eq));
    check("out_r", 32'(Out_r), 32'(er));
    check("out_dz", 32'(Out_dz), 32'(edz));
    check("out_to", 32'(Out_to), 32'(eto));
    check("in_ready_busy", 32'(In_ready), 32'd0);

    for (int h = 0; h < hold; h++) begin
      @(negedge Clk);
      check("hold_valid", 32'(Out_valid), 32'd1);
      check("hold_q", 32'(Out_q), 32'(eq));
      check("hold_r", 32'(Out_r), 32'(er));
      check("hold_in_ready", 32'(In_ready), 32'd0);
    end

    Out_ready = 1'b1;
    @(negedge Clk);
    Out_ready = 1'b0;
    check("valid_cleared", 32'(Out_valid), 32'd0);
    check("in_ready_idle", 32'(In_ready), 32'd1);
    check("q_held_after", 32'(Out_q), 32'(eq));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(In_ready), 32'd1);
    check({tag, "_start"}, 32'(Start), 32'd0);
    check({tag, "_data_in"}, 32'(Data_in), 32'd0);
    check({tag, "_out_valid"}, 32'(Out_valid), 32'd0);
    check({tag, "_out_q"}, 32'(Out_q), 32'd0);
    check({tag, "_out_r"}, 32'(Out_r), 32'd0);
    check({tag, "_out_dz"}, 32'(Out_dz), 32'd0);
    check({tag, "_out_to"}, 32'(Out_to), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [W-1:0] rn, rp;

    repeat (2) @(negedge Clk);
    check_reset_values("reset");
    Rst_n = 1'b1;
    @(negedge Clk);

    run_op(8'd53,  8'd23, 0, 0);
    run_op(8'd250, 8'd15, 0, 0);
    run_op(8'd16,  8'd3,  0, 0);   // back-to-back, Stop still high from before
    run_op(8'd100, 8'd9,  5, 0);   // consumer stalls 5 cycles
    run_op(8'd15,  8'd0,  1, 0);   // divide by zero
    run_op(8'd77,  8'd5,  0, 1);   // divider stuck: timeout
    run_op(8'd77,  8'd5,  0, 2);   // Stop on terminal cycle wins

    // Reset in the middle of WAIT.
    stub_mode = 1'b0;
    In_valid = 1'b1;
    In_n = 8'd100;
    In_p = 8'd7;
    @(posedge Clk);
    @(negedge Clk);
    In_valid = 1'b0;
    repeat (7) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    run_op(8'd59, 8'd11, 0, 0);

    for (int i = 0; i < 12; i++) begin
      rn = W'($urandom);
      rp = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      run_op(rn, rp, int'($urandom_range(0, 3)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
